vend_txn_controller: RTL and testbench

Sequences one vending transaction around the coin encoder and the credit/next-state datapath. It accepts encoded coins through a valid/ready handshake and accumulates credit in 5-cent units. It pulses the dispense actuator once credit reaches the price, then returns change coin-by-coin with an acknowledge handshake. It also handles cancel and inactivity timeout by refunding all held credit.

---
 rtl/vend_txn_controller_if.sv | 25 ++
 rtl/vend_txn_controller.sv | 141 ++++++++++++++
 tb/tb_vend_txn_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vend_txn_controller_if.sv
// rtl/vend_txn_controller_if.sv - coin intake, dispense and change signals of the vending controller
interface vend_txn_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                coin_ready;
    logic                cancel;
    logic                dispense;
    logic                change_valid;
    logic [1:0]          change_coin;
    logic                change_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_valid, coin_code, cancel, change_ack,
        input  coin_ready, dispense, change_valid, change_coin, credit, busy
    );

    modport slave (
        input  coin_valid, coin_code, cancel, change_ack,
        output coin_ready, dispense, change_valid, change_coin, credit, busy
    );
endinterface

// File: rtl/vend_txn_controller.sv
// rtl/vend_txn_controller.sv - vending transaction FSM: coin credit, dispense pulse, greedy change/refund
module vend_txn_controller #(
    parameter int PRICE           = 4,
    parameter int CREDIT_W        = 4,
    parameter int DISPENSE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 8
) (
    input  logic     clk,
    input  logic     reset,
    vend_txn_if.slave bus
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DSP_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DSP_W-1:0]    DSP_LAST = DSP_W'(DISPENSE_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] L_PRICE  = CREDIT_W'(PRICE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DISPENSE,
        S_CHANGE,
        S_REFUND
    } state_t;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return CREDIT_W'(1);
            2'b10:   return CREDIT_W'(2);
            2'b11:   return CREDIT_W'(5);
            default: return '0;
        endcase
    endfunction

    // Largest single coin not exceeding the amount still owed.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amount);
        if (amount >= CREDIT_W'(5))
            return 2'b11;
        else if (amount >= CREDIT_W'(2))
            return 2'b10;
        else
            return 2'b01;
    endfunction

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [TMO_W-1:0]    r_tmo;
    logic [DSP_W-1:0]    r_dcnt;
    logic                r_dispense;
    logic                r_change_valid;
    logic [1:0]          r_change_coin;

    logic                w_coin_ready;
    logic                w_coin_accept;
    logic [CREDIT_W-1:0] w_credit_sum;
    logic [CREDIT_W-1:0] w_credit_after_price;
    logic [CREDIT_W-1:0] w_credit_after_change;

    assign w_coin_ready          = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_coin_accept         = bus.coin_valid && w_coin_ready && (bus.coin_code != 2'b00);
    assign w_credit_sum          = r_credit + coin_value(bus.coin_code);
    assign w_credit_after_price  = r_credit - L_PRICE;
    assign w_credit_after_change = r_credit - coin_value(r_change_coin);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_tmo          <= '0;
            r_dcnt         <= '0;
            r_dispense     <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_coin  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_coin_accept) begin
                        r_credit <= w_credit_sum;
                        r_tmo    <= '0;
                        // Cancel only matters once credit is held; it then beats dispense.
                        if (r_state == S_ACCUM && bus.cancel) begin
                            r_state        <= S_REFUND;
                            r_change_valid <= 1'b1;
                            r_change_coin  <= greedy_coin(w_credit_sum);
                        end else if (w_credit_sum >= L_PRICE) begin
                            r_state    <= S_DISPENSE;
                            r_dcnt     <= '0;
                            r_dispense <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end else if (r_state == S_IDLE) begin
                        r_tmo <= '0;
                    end else if (bus.cancel || r_tmo == TMO_LAST) begin
                        r_state        <= S_REFUND;
                        r_tmo          <= '0;
                        r_change_valid <= 1'b1;
                        r_change_coin  <= greedy_coin(r_credit);
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DISPENSE: begin
                    if (r_dcnt == DSP_LAST) begin
                        r_dispense <= 1'b0;
                        r_credit   <= w_credit_after_price;
                        if (w_credit_after_price != '0) begin
                            r_state        <= S_CHANGE;
                            r_change_valid <= 1'b1;
                            r_change_coin  <= greedy_coin(w_credit_after_price);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_CHANGE, S_REFUND: begin
                    if (bus.change_ack) begin
                        r_credit <= w_credit_after_change;
                        if (w_credit_after_change == '0) begin
                            r_state        <= S_IDLE;
                            r_change_valid <= 1'b0;
                            r_change_coin  <= 2'b00;
                        end else begin
                            r_change_coin <= greedy_coin(w_credit_after_change);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.coin_ready   = w_coin_ready;
    assign bus.dispense     = r_dispense;
    assign bus.change_valid = r_change_valid;
    assign bus.change_coin  = r_change_coin;
    assign bus.credit       = r_credit;
    assign bus.busy         = (r_state == S_DISPENSE) || (r_state == S_CHANGE) || (r_state == S_REFUND);
endmodule

// File: tb/tb_vend_txn_controller.sv
// tb/tb_vend_txn_controller.sv - directed and random checks of vend_txn_controller against a behavioural model
module tb_vend_txn_controller;
    localparam int PRICE           = 4;
    localparam int CREDIT_W        = 4;
    localparam int DISPENSE_CYCLES = 2;
    localparam int TIMEOUT_CYCLES  = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    vend_txn_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_txn_controller #(
        .PRICE(PRICE),
        .CREDIT_W(CREDIT_W),
        .DISPENSE_CYCLES(DISPENSE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: money held, dispense cycles still owed, whether coins are being paid back, idle count.
    int m_credit;
    int m_disp_left;
    bit m_paying;
    int m_idle;

    function automatic int cval(input logic [1:0] code);
        case (code)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] best_coin(input int amount);
        if (amount >= 5) return 2'b11;
        if (amount >= 2) return 2'b10;
        return 2'b01;
    endfunction

    task automatic model_step(input logic v, input logic [1:0] c, input logic can,
                              input logic ack, input logic rst);
        if (rst) begin
            m_credit = 0; m_disp_left = 0; m_paying = 0; m_idle = 0;
        end else if (m_disp_left > 0) begin
            m_disp_left--;
            if (m_disp_left == 0) begin
                m_credit -= PRICE;
                m_paying = (m_credit > 0);
            end
        end else if (m_paying) begin
            if (ack) begin
                m_credit -= cval(best_coin(m_credit));
                if (m_credit == 0) m_paying = 0;
            end
        end else if (v && c != 2'b00) begin
            bit was_holding = (m_credit > 0);
            m_credit += cval(c);
            m_idle = 0;
            if (was_holding && can) m_paying = 1;
            else if (m_credit >= PRICE) m_disp_left = DISPENSE_CYCLES;
        end else if (m_credit > 0) begin
            if (can || m_idle == TIMEOUT_CYCLES - 1) begin
                m_paying = 1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] c, input logic can,
                       input logic ack, input logic rst, input string tag);
        bus.coin_valid = v;
        bus.coin_code  = c;
        bus.cancel     = can;
        bus.change_ack = ack;
        reset          = rst;
        @(posedge clk);
        model_step(v, c, can, ack, rst);
        @(negedge clk);
        chk({tag, ".credit"},       32'(bus.credit),       32'(m_credit));
        chk({tag, ".dispense"},     32'(bus.dispense),     32'(m_disp_left > 0));
        chk({tag, ".coin_ready"},   32'(bus.coin_ready),   32'(m_disp_left == 0 && !m_paying));
        chk({tag, ".change_valid"}, 32'(bus.change_valid), 32'(m_paying));
        chk({tag, ".change_coin"},  32'(bus.change_coin),  32'(m_paying ? best_coin(m_credit) : 2'b00));
        chk({tag, ".busy"},         32'(bus.busy),         32'(m_disp_left > 0 || m_paying));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int disp_count;
        m_credit = 0; m_disp_left = 0; m_paying = 0; m_idle = 0;
        bus.coin_valid = 1'b0; bus.coin_code = 2'b00; bus.cancel = 1'b0; bus.change_ack = 1'b0;
        reset = 1'b1;

        cyc(0, 2'b00, 0, 0, 1, "por");
        cyc(0, 2'b00, 0, 0, 1, "por");
        chk("por_credit", 32'(bus.credit), 0);
        chk("por_ready",  32'(bus.coin_ready), 1);

        // Reset while holding credit 3 in ACCUM
        cyc(1, 2'b10, 0, 0, 0, "t1");
        cyc(1, 2'b01, 0, 0, 0, "t1");
        chk("t1_credit3", 32'(bus.credit), 3);
        cyc(0, 2'b00, 0, 0, 1, "t1r");
        cyc(0, 2'b00, 0, 0, 1, "t1r");
        chk("t1_rst_credit", 32'(bus.credit), 0);
        chk("t1_rst_ready",  32'(bus.coin_ready), 1);
        chk("t1_rst_busy",   32'(bus.busy), 0);

        // Exact price, no change
        cyc(1, 2'b10, 0, 0, 0, "t2");
        chk("t2_credit2", 32'(bus.credit), 2);
        cyc(1, 2'b10, 0, 0, 0, "t2");
        chk("t2_credit4", 32'(bus.credit), 4);
        disp_count = 32'(bus.dispense);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'b00, 0, 0, 0, "t2d");
            disp_count += 32'(bus.dispense);
        end
        chk("t2_disp_cycles", 32'(disp_count), 2);
        chk("t2_credit0", 32'(bus.credit), 0);
        chk("t2_no_change", 32'(bus.change_valid), 0);

        // Quarter: one nickel change, held through three unacked cycles
        cyc(1, 2'b11, 0, 0, 0, "t3");
        chk("t3_credit5", 32'(bus.credit), 5);
        idle(2, "t3d");
        chk("t3_cv", 32'(bus.change_valid), 1);
        chk("t3_coin", 32'(bus.change_coin), 1);
        chk("t3_credit1", 32'(bus.credit), 1);
        idle(3, "t3hold");
        chk("t3_hold_coin", 32'(bus.change_coin), 1);
        cyc(0, 2'b00, 0, 1, 0, "t3ack");
        chk("t3_done_credit", 32'(bus.credit), 0);
        chk("t3_done_cv", 32'(bus.change_valid), 0);

        // Dime + quarter: change 10 then 01 on back-to-back acks
        cyc(1, 2'b10, 0, 0, 0, "t4");
        cyc(1, 2'b11, 0, 0, 0, "t4");
        chk("t4_credit7", 32'(bus.credit), 7);
        idle(2, "t4d");
        chk("t4_credit3", 32'(bus.credit), 3);
        chk("t4_coin10", 32'(bus.change_coin), 2);
        cyc(0, 2'b00, 0, 1, 0, "t4ack");
        chk("t4_coin01", 32'(bus.change_coin), 1);
        cyc(0, 2'b00, 0, 1, 0, "t4ack");
        chk("t4_done", 32'(bus.credit), 0);
        chk("t4_done_busy", 32'(bus.busy), 0);

        // Cancel together with a dime refunds the sum
        cyc(1, 2'b01, 0, 0, 0, "t5");
        cyc(1, 2'b10, 1, 0, 0, "t5c");
        chk("t5_credit3", 32'(bus.credit), 3);
        chk("t5_nodisp", 32'(bus.dispense), 0);
        chk("t5_coin10", 32'(bus.change_coin), 2);
        cyc(0, 2'b00, 0, 1, 0, "t5ack");
        chk("t5_coin01", 32'(bus.change_coin), 1);
        cyc(0, 2'b00, 0, 1, 0, "t5ack");
        cyc(0, 2'b00, 1, 0, 0, "t5idle");
        chk("t5_idle_cancel_busy", 32'(bus.busy), 0);
        chk("t5_idle_cancel_ready", 32'(bus.coin_ready), 1);

        // Timeout: seven idle cycles (some with code 00) stay, the eighth refunds
        cyc(1, 2'b01, 0, 0, 0, "t6");
        for (int i = 0; i < 7; i++) cyc(i[0], 2'b00, 0, 0, 0, "t6w");
        chk("t6_not_yet", 32'(bus.busy), 0);
        cyc(1, 2'b00, 0, 0, 0, "t6w");
        chk("t6_refund", 32'(bus.change_valid), 1);
        chk("t6_coin01", 32'(bus.change_coin), 1);
        cyc(0, 2'b00, 0, 1, 0, "t6ack");

        // Reset during the first dispense cycle
        cyc(1, 2'b11, 0, 0, 0, "t6q");
        chk("t6_disp_on", 32'(bus.dispense), 1);
        cyc(0, 2'b00, 0, 0, 1, "t6r");
        chk("t6_disp_off", 32'(bus.dispense), 0);
        chk("t6_credit0", 32'(bus.credit), 0);

        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 49) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
